// File: rtl/gpu_pkg.sv
// Shared GPU definitions: screen size, fragment record layout and the record
// packing helper used by both ends of the z-buffer fragment queue.
package gpu_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int FRAG_W    = 256;
    localparam int FRAG_X_HI = 255;
    localparam int FRAG_X_LO = 240;
    localparam int FRAG_Y_HI = 239;
    localparam int FRAG_Y_LO = 224;
    localparam int FRAG_Z_HI = 223;
    localparam int FRAG_Z_LO = 208;
    localparam int FRAG_R_HI = 63;
    localparam int FRAG_R_LO = 48;
    localparam int FRAG_G_HI = 47;
    localparam int FRAG_G_LO = 32;
    localparam int FRAG_B_HI = 31;
    localparam int FRAG_B_LO = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } wr_state_e;

    // Colour channels sit in the low byte of their 16-bit field; every
    // unlisted bit of the record is zero.
    function automatic logic [FRAG_W-1:0] frag_pack(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z,
        input logic [7:0]  r,
        input logic [7:0]  g,
        input logic [7:0]  b
    );
        logic [FRAG_W-1:0] rec;
        rec                       = '0;
        rec[FRAG_X_HI:FRAG_X_LO]  = x;
        rec[FRAG_Y_HI:FRAG_Y_LO]  = y;
        rec[FRAG_Z_HI:FRAG_Z_LO]  = z;
        rec[FRAG_R_HI:FRAG_R_LO]  = {8'h00, r};
        rec[FRAG_G_HI:FRAG_G_LO]  = {8'h00, g};
        rec[FRAG_B_HI:FRAG_B_LO]  = {8'h00, b};
        return rec;
    endfunction

endpackage

// File: rtl/zqueue_fragment_writer_span_stepper.sv
// Walks one span pixel by pixel: holds the current x and depth, and flags the
// last pixel of the span and pixels lying outside the screen.
module span_stepper #(
    parameter int SCREEN_W = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] z0,
    input  logic [15:0] dz,
    output logic [15:0] cur_x,
    output logic [15:0] cur_z,
    output logic        last,
    output logic        offscreen
);

    // x is kept 17 bits wide so a span ending at 16'h7FFF compares and
    // terminates without the increment wrapping negative.
    localparam logic signed [16:0] X_LIMIT = 17'(SCREEN_W);

    logic signed [16:0] cur_x_r;
    logic signed [16:0] x1_r;
    logic        [15:0] cur_z_r;
    logic        [15:0] dz_r;

    // Span position registers: load on a new span, step on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x_r <= 17'sd0;
            x1_r    <= 17'sd0;
            cur_z_r <= 16'h0000;
            dz_r    <= 16'h0000;
        end else if (load) begin
            cur_x_r <= {x0[15], x0};
            x1_r    <= {x1[15], x1};
            cur_z_r <= z0;
            dz_r    <= dz;
        end else if (advance) begin
            cur_x_r <= cur_x_r + 17'sd1;
            cur_z_r <= cur_z_r + dz_r;
        end else begin
            cur_x_r <= cur_x_r;
            x1_r    <= x1_r;
            cur_z_r <= cur_z_r;
            dz_r    <= dz_r;
        end
    end

    assign cur_x     = cur_x_r[15:0];
    assign cur_z     = cur_z_r;
    assign last      = (cur_x_r == x1_r);
    assign offscreen = (cur_x_r < 17'sd0) || (cur_x_r >= X_LIMIT);

endmodule

// File: rtl/zqueue_fragment_writer.sv
// Producer end of the z-buffer fragment queue: expands span descriptors into
// one 256-bit fragment record per on-screen pixel, throttled on queue size.
module zqueue_fragment_writer #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int HIGH_WATER = 254
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         span_valid,
    output logic         span_ready,
    input  logic [15:0]  span_y,
    input  logic [15:0]  span_x0,
    input  logic [15:0]  span_x1,
    input  logic [15:0]  span_z0,
    input  logic [15:0]  span_dz,
    input  logic [23:0]  span_rgb,
    input  logic [15:0]  z_size,
    output logic         z_adding,
    output logic [255:0] z_add_regs,
    output logic         busy,
    output logic [31:0]  frag_count
);

    import gpu_pkg::*;

    localparam logic signed [15:0] Y_LIMIT   = 16'(SCREEN_H);
    localparam logic        [16:0] HW_LIMIT  = 17'(HIGH_WATER);

    wr_state_e      state_r;
    wr_state_e      state_next;
    logic [15:0]    y_r;
    logic [23:0]    rgb_r;
    logic           span_ready_r;
    logic           busy_r;
    logic           z_adding_r;
    logic [255:0]   z_add_regs_r;
    logic [31:0]    frag_count_r;

    logic           load_s;
    logic           advance_s;
    logic           push_s;
    logic           empty_s;
    logic           room_s;
    logic [15:0]    cur_x_s;
    logic [15:0]    cur_z_s;
    logic           last_s;
    logic           offscreen_s;

    span_stepper #(
        .SCREEN_W (SCREEN_W)
    ) u_stepper (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .advance   (advance_s),
        .x0        (span_x0),
        .x1        (span_x1),
        .z0        (span_z0),
        .dz        (span_dz),
        .cur_x     (cur_x_s),
        .cur_z     (cur_z_s),
        .last      (last_s),
        .offscreen (offscreen_s)
    );

    // A span with nothing to draw is swallowed in IDLE without entering EMIT.
    assign empty_s = ($signed(span_x1) < $signed(span_x0))
                  || ($signed(span_y) < 16'sd0)
                  || ($signed(span_y) >= Y_LIMIT);

    // The queue's size lags our push by a cycle, so the record presented
    // right now still counts against the high-water mark.
    assign room_s = (({1'b0, z_size} + {16'h0000, z_adding_r}) < HW_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and per-pixel push/advance decisions.
    always_comb begin
        state_next = state_r;
        load_s     = 1'b0;
        advance_s  = 1'b0;
        push_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (span_valid && span_ready_r) begin
                    if (empty_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        load_s     = 1'b1;
                        state_next = ST_EMIT;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (offscreen_s) begin
                    advance_s = 1'b1;
                end else if (room_s) begin
                    push_s    = 1'b1;
                    advance_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
                if (advance_s && last_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_EMIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the per-span constants that go into every record.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r   <= 16'h0000;
            rgb_r <= 24'h000000;
        end else if (load_s) begin
            y_r   <= span_y;
            rgb_r <= span_rgb;
        end else begin
            y_r   <= y_r;
            rgb_r <= rgb_r;
        end
    end

    // Registered outputs: handshake/busy follow the next state, the record
    // and strobe appear the cycle after the push decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            span_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            z_adding_r   <= 1'b0;
            z_add_regs_r <= 256'h0;
            frag_count_r <= 32'h0000_0000;
        end else begin
            span_ready_r <= (state_next == ST_IDLE);
            busy_r       <= (state_next == ST_EMIT);
            z_adding_r   <= push_s;
            if (push_s) begin
                z_add_regs_r <= frag_pack(cur_x_s, y_r, cur_z_s,
                                          rgb_r[23:16], rgb_r[15:8], rgb_r[7:0]);
                frag_count_r <= frag_count_r + 32'h0000_0001;
            end else begin
                z_add_regs_r <= z_add_regs_r;
                frag_count_r <= frag_count_r;
            end
        end
    end

    assign span_ready = span_ready_r;
    assign busy       = busy_r;
    assign z_adding   = z_adding_r;
    assign z_add_regs = z_add_regs_r;
    assign frag_count = frag_count_r;

endmodule
